// File: rtl/ntt_dispatch_queue.sv
// Command FIFO feeding an NTT core through a request/grant handshake.
// Tracks head-of-queue starvation and a saturating count of denied request cycles.
module ntt_dispatch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CMD_W        = 8,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_bank_mask,
  input  logic [CMD_W-1:0]         cmd_payload,
  output logic                     start_req,
  output logic [3:0]               bank_mask,
  input  logic                     grant_start,
  output logic                     core_start,
  output logic [CMD_W-1:0]         core_payload,
  input  logic                     core_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     starve,
  output logic [15:0]              denied_total
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned EW = CMD_W + 4;

  typedef enum logic [1:0] {StIdle, StReq, StWaitBusy, StRun} state_e;

  state_e             state_q, state_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [WW-1:0]      wait_q;
  logic [15:0]        denied_q;
  logic               core_start_q;
  logic [CMD_W-1:0]   core_payload_q;

  logic               push, pop, deny;
  logic [EW-1:0]      head;

  assign head      = mem_q[rd_ptr_q];
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    state_d   = state_q;
    start_req = 1'b0;
    bank_mask = 4'b0;
    pop       = 1'b0;
    deny      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0 && !core_busy) state_d = StReq;
      end
      StReq: begin
        start_req = 1'b1;
        bank_mask = head[EW-1:CMD_W];
        if (grant_start) begin
          pop     = 1'b1;
          state_d = StWaitBusy;
        end else begin
          deny = 1'b1;
        end
      end
      StWaitBusy: begin
        if (core_busy) state_d = StRun;
      end
      StRun: begin
        if (!core_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; validity is defined solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_bank_mask, cmd_payload};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      wait_q         <= '0;
      denied_q       <= '0;
      core_start_q   <= 1'b0;
      core_payload_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      core_start_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q       <= rd_ptr_q + AW'(1);
        core_payload_q <= head[CMD_W-1:0];
        wait_q         <= '0;
      end else if (deny) begin
        if (wait_q != WW'(STARVE_LIMIT)) wait_q <= wait_q + WW'(1);
        if (denied_q != 16'hFFFF) denied_q <= denied_q + 16'd1;
      end
    end
  end

  assign core_start   = core_start_q;
  assign core_payload = core_payload_q;
  assign fifo_count   = count_q;
  assign starve       = (wait_q == WW'(STARVE_LIMIT));
  assign denied_total = denied_q;

endmodule

// File: tb/tb_ntt_dispatch_queue.sv
// Randomized and directed bench for ntt_dispatch_queue with a queue-based reference model
// and a scoreboard that checks every launched payload in order.
module tb_ntt_dispatch_queue;

  localparam int DEPTH = 4;
  localparam int LIMIT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_bank_mask;
  logic [7:0] cmd_payload;
  logic       start_req;
  logic [3:0] bank_mask;
  logic       grant_start;
  logic       core_start;
  logic [7:0] core_payload;
  logic       core_busy;
  logic [2:0] fifo_count;
  logic       starve;
  logic [15:0] denied_total;

  int errors = 0;
  int checks = 0;

  // Reference model: queued commands, phase name per the state list, counters.
  logic [11:0] m_q[$];
  logic [7:0]  sb[$];
  int          ph;          // 0 idle, 1 requesting, 2 waiting for busy, 3 running
  int          m_wait, m_denied;
  logic        m_cs;
  logic [7:0]  m_pay;

  ntt_dispatch_queue #(.DEPTH(DEPTH), .CMD_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_bank_mask(cmd_bank_mask), .cmd_payload(cmd_payload), .start_req(start_req),
    .bank_mask(bank_mask), .grant_start(grant_start), .core_start(core_start),
    .core_payload(core_payload), .core_busy(core_busy), .fifo_count(fifo_count),
    .starve(starve), .denied_total(denied_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    ph = 0; m_wait = 0; m_denied = 0; m_cs = 1'b0; m_pay = 8'h00;
  endtask

  task automatic model_step(input logic v, input logic [3:0] m, input logic [7:0] p,
                            input logic g, input logic b);
    int  sz  = m_q.size();
    bit  acc = v && (sz != DEPTH);
    bit  gr  = (ph == 1) && g;
    m_cs = gr;
    if (gr) begin
      m_pay = m_q[0][7:0];
      sb.push_back(m_q[0][7:0]);
      void'(m_q.pop_front());
      m_wait = 0;
    end else if (ph == 1) begin
      if (m_wait < LIMIT) m_wait++;
      if (m_denied < 65535) m_denied++;
    end
    if (acc) m_q.push_back({m, p});
    case (ph)
      0: if (sz != 0 && !b) ph = 1;
      1: if (g) ph = 2;
      2: if (b) ph = 3;
      default: if (!b) ph = 0;
    endcase
  endtask

  task automatic check_all();
    logic [11:0] hd;
    hd = (m_q.size() != 0) ? m_q[0] : 12'h000;
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_q.size() != DEPTH));
    chk("start_req", 32'(start_req), 32'(ph == 1));
    chk("bank_mask", 32'(bank_mask), (ph == 1) ? 32'(hd[11:8]) : 32'd0);
    chk("starve", 32'(starve), 32'(m_wait == LIMIT));
    chk("denied_total", 32'(denied_total), 32'(m_denied));
    chk("core_start", 32'(core_start), 32'(m_cs));
    chk("core_payload", 32'(core_payload), 32'(m_pay));
  endtask

  // Called at a falling edge; drives inputs, advances the model, checks at the next fall.
  task automatic cycle(input logic v, input logic [3:0] m, input logic [7:0] p,
                       input logic g, input logic b);
    cmd_valid = v; cmd_bank_mask = m; cmd_payload = p; grant_start = g; core_busy = b;
    model_step(v, m, p, g, b);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; grant_start = 1'b0; core_busy = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_start_req", 32'(start_req), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_core_payload", 32'(core_payload), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_denied", 32'(denied_total), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  task automatic drain();
    int n = 0;
    while ((m_q.size() != 0 || ph != 0) && n < 200) begin
      cycle(1'b0, 4'h0, 8'h00, 1'b1, (n % 3) == 1);
      n++;
    end
    chk("drain_bound", 32'(n < 200), 32'd1);
  endtask

  // Scoreboard monitor: every launch pulse must match the oldest expected payload.
  always @(negedge clk) begin
    if (!rst && core_start) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_start", 32'(core_start), 32'd0);
      end else begin
        chk("sb_payload", 32'(core_payload), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    int gp;
    rst = 1'b1; cmd_valid = 1'b0; cmd_bank_mask = 4'h0; cmd_payload = 8'h00;
    grant_start = 1'b0; core_busy = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Single command, grant always high.
    cycle(1'b1, 4'b0011, 8'hA5, 1'b1, 1'b0);
    chk("d1_no_req_yet", 32'(start_req), 32'd0);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    chk("d1_req", 32'(start_req), 32'd1);
    chk("d1_mask", 32'(bank_mask), 32'h3);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    chk("d1_pulse", 32'(core_start), 32'd1);
    chk("d1_payload", 32'(core_payload), 32'hA5);
    chk("d1_empty", 32'(fifo_count), 32'd0);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b1);
    chk("d1_pulse_end", 32'(core_start), 32'd0);
    drain();

    // Fill to full with no grant, refuse a fifth, then grant and refill.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 1), 8'(8'h10 + i), 1'b0, 1'b0);
    chk("d2_full_ready", 32'(cmd_ready), 32'd0);
    chk("d2_full_count", 32'(fifo_count), 32'd4);
    cycle(1'b1, 4'hF, 8'hEE, 1'b0, 1'b0);
    chk("d2_no_fifth", 32'(fifo_count), 32'd4);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    chk("d2_after_grant", 32'(fifo_count), 32'd3);
    cycle(1'b1, 4'hF, 8'hEE, 1'b0, 1'b0);
    chk("d2_refill", 32'(fifo_count), 32'd4);
    drain();

    // Twenty denied cycles: starve from the 16th, then cleared by a grant.
    do_reset();
    cycle(1'b1, 4'h5, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      chk("d3_starve", 32'(starve), 32'(i >= 16));
    end
    chk("d3_denied20", 32'(denied_total), 32'd20);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    chk("d3_starve_clear", 32'(starve), 32'd0);
    drain();

    // Busy core holds off the second command.
    do_reset();
    cycle(1'b1, 4'h1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 8'h22, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b1);
      chk("d4_held", 32'(start_req), 32'd0);
    end
    cycle(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("d4_idle", 32'(start_req), 32'd0);
    cycle(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("d4_req2", 32'(start_req), 32'd1);
    chk("d4_mask2", 32'(bank_mask), 32'h2);
    drain();

    // Reset while running with three queued.
    do_reset();
    cycle(1'b1, 4'h1, 8'hA1, 1'b1, 1'b0);
    cycle(1'b1, 4'h2, 8'hB2, 1'b1, 1'b0);
    cycle(1'b1, 4'h4, 8'hC3, 1'b1, 1'b0);
    cycle(1'b1, 4'h8, 8'hD4, 1'b0, 1'b1);
    chk("d5_queued", 32'(fifo_count), 32'd3);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
      chk("d5_no_start", 32'(core_start), 32'd0);
    end

    // Simultaneous push and pop, then a full-FIFO pop blocking the push, across wrap.
    do_reset();
    cycle(1'b1, 4'h1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 8'h32, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 8'h33, 1'b1, 1'b0);
    chk("d6_pushpop", 32'(fifo_count), 32'd2);
    cycle(1'b1, 4'h4, 8'h34, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 4'h5, 8'h35, 1'b0, 1'b0);
    cycle(1'b1, 4'h6, 8'h36, 1'b1, 1'b0);
    chk("d6_full_pop", 32'(fifo_count), 32'd3);
    drain();

    // Randomized traffic with varying grant pressure and occasional resets.
    gp = 5;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) gp = $urandom_range(0, 10);
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle($urandom_range(0, 1) == 1, 4'($urandom), 8'($urandom),
                 $urandom_range(0, 9) < gp, $urandom_range(0, 1) == 1);
    end
    drain();
    cycle(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
